ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock, rising edge; nRST  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have ports: iREN  in  2  per-core instruction read request (bit n = core n); dREN  in  2  per-core data read request; dWEN  in  2  per-core data write request.
REQ-003 SHALL have ports: iaddr  in  2x32  per-core fetch address; daddr  in  2x32  per-core data address; dstore  in  2x32  per-core write data.
REQ-004 SHALL have ports: iwait  out  2  per-core fetch stall; dwait  out  2  per-core data stall; iload  out  2x32  fetch data; dload  out  2x32  read data.
REQ-005 SHALL have ports: ramREN  out  1; ramWEN  out  1; ramaddr  out  32; ramstore  out  32; ramload  in  32; ramstate  in  2  ramstate_t {FREE, BUSY, ACCESS, ERROR}.

Function
REQ-006 SHALL implement FSM states IDLE and SERVE; one RAM transaction outstanding at most.
REQ-007 In IDLE with any request bit set, SHALL select one requester, latch {core, kind}, and enter SERVE next cycle; no RAM request is driven in IDLE.
REQ-008 Within the selected core, SHALL give data over instruction; dWEN over dREN if both asserted.
REQ-009 Between cores, SHALL select per the arbitration policy in the Configuration section.
REQ-010 In SERVE, SHALL drive ramREN/ramWEN, ramaddr and ramstore from the latched requester's live inputs; all other cycles ramREN=ramWEN=0, ramaddr=0, ramstore=0.
REQ-011 In SERVE with ramstate==ACCESS, SHALL deassert the granted requester's wait bit for that cycle only, route ramload to its iload/dload, and return to IDLE.
REQ-012 Wait bits SHALL be 1 whenever the corresponding request is asserted and not being completed; 0 when that request is deasserted.
REQ-013 iload/dload SHALL equal ramload for the completing requester in its ACCESS cycle and 0 otherwise.
REQ-014 In SERVE with ramstate BUSY, FREE or ERROR, SHALL remain in SERVE, retrying until ACCESS.
REQ-015 If the granted request deasserts during SERVE, SHALL return to IDLE next cycle without a wait pulse or updating arbitration history.
REQ-016 Minimum latency SHALL be 2 cycles from request assertion to wait deassertion; new grant no earlier than the cycle after completion.

Reset
REQ-017 On nRST low, SHALL immediately enter IDLE, clear latched grant, set last-served core to 1 (core 0 wins the first tie), and drive all RAM outputs 0 and iload/dload 0.
REQ-018 Reset asserted mid-SERVE SHALL abandon the transaction; no completion pulse issued.

Configuration
REQ-019 With macro ARB_ROUND_ROBIN_EN defined, SHALL grant the core not served most recently when both cores request; last-served core updates only on completion.
REQ-020 Without ARB_ROUND_ROBIN_EN, SHALL use fixed priority: core 0 always wins a tie.

Structure
REQ-021 ramstate_t, word_t and arbiter state enum SHALL reside in cpu_types_pkg.
REQ-022 Requester selection SHALL be a combinational sub-module arb_select (inputs: request bits, last-served core; outputs: core, kind, valid).

Verification
REQ-023 Core0 dREN=1, daddr=0x40, RAM ACCESS on 2nd SERVE cycle with ramload=0xDEADBEEF -> dwait[0] low exactly one cycle, dload[0]=0xDEADBEEF, latency 3 cycles.
REQ-024 Core0 iREN and dWEN same cycle, dstore=0x12345678 -> write served first (ramWEN=1, ramstore=0x12345678), then fetch.
REQ-025 Both cores dREN held continuously, ACCESS every 2nd cycle -> with ARB_ROUND_ROBIN_EN grants alternate 0,1,0,1; without, core 0 served repeatedly, core 1 starved.
REQ-026 Core1 iREN dropped after 1 SERVE cycle with ramstate BUSY -> FSM to IDLE, iwait[1]=0, no ramload routed, next tie still favours core 1 under round-robin.
REQ-027 nRST pulsed low during SERVE -> ramREN/ramWEN 0 asynchronously, no wait pulse, first post-reset tie granted to core 0.
REQ-028 ramstate=ERROR for 3 cycles then ACCESS -> requester wait held high throughout, completes on ACCESS cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the dual-core RAM arbiter: RAM handshake states, the
// data word, the arbiter FSM encoding and the latched grant record.
package cpu_types_pkg;

    localparam int NUM_CORES = 2;
    localparam int WORD_W    = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Status reported by the RAM each cycle; only ACCESS completes a transfer.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter FSM: IDLE picks a requester, SERVE owns the RAM for it.
    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    // Which of a core's three request lines a grant belongs to.
    typedef enum logic [1:0] {
        KIND_IFETCH = 2'd0,
        KIND_DREAD  = 2'd1,
        KIND_DWRITE = 2'd2
    } req_kind_t;

    typedef logic core_id_t;

    typedef struct packed {
        core_id_t  core;
        req_kind_t kind;
    } grant_t;

    // Inside one core a store beats a load, and any data access beats a fetch.
    function automatic req_kind_t pick_kind(input logic dren, input logic dwen);
        req_kind_t kind;
        if (dwen) begin
            kind = KIND_DWRITE;
        end else if (dren) begin
            kind = KIND_DREAD;
        end else begin
            kind = KIND_IFETCH;
        end
        return kind;
    endfunction

endpackage

// File: rtl/arb_select.sv
// Combinational requester selection for the RAM arbiter.
// Picks the core to serve next and which of its requests goes first.
// Build option: define ARB_ROUND_ROBIN_EN to alternate cores on a tie;
// otherwise core 0 always wins a tie.
module arb_select
    import cpu_types_pkg::*;
(
    input  logic [NUM_CORES-1:0] iren_i,
    input  logic [NUM_CORES-1:0] dren_i,
    input  logic [NUM_CORES-1:0] dwen_i,
    input  core_id_t             last_core_i,
    output core_id_t             core_o,
    output req_kind_t            kind_o,
    output logic                 valid_o
);

    logic [NUM_CORES-1:0] core_req;

    assign core_req = iren_i | dren_i | dwen_i;
    assign valid_o  = |core_req;

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority ignores the history; keep it visibly consumed.
    logic unused_last_core;
    assign unused_last_core = last_core_i;
`endif

    // Choose between cores: a lone requester wins, a tie follows the policy.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the block can leave it unassigned (no latch).
        core_o = 1'b0;
        if (core_req == 2'b10) begin
            core_o = 1'b1;
        end else if (core_req == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
            core_o = ~last_core_i;
`else
            core_o = 1'b0;
`endif
        end
    end

    // Choose the request kind within the selected core.
    always_comb begin
        kind_o = pick_kind(dren_i[core_o], dwen_i[core_o]);
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-core RAM arbiter: shares one single-port RAM between the instruction
// and data ports of two cores, with at most one RAM transaction in flight.
// IDLE selects a requester and latches {core, kind}; SERVE drives the RAM
// from that requester's live inputs until ramstate reports ACCESS or the
// request is withdrawn.
// Build option: ARB_ROUND_ROBIN_EN (round-robin between cores on a tie;
// default build uses fixed priority with core 0 first).
module ram_arbiter
    import cpu_types_pkg::*;
(
    input  logic                 CLK,
    input  logic                 nRST,
    // core-side requests
    input  logic [NUM_CORES-1:0] iREN,
    input  logic [NUM_CORES-1:0] dREN,
    input  logic [NUM_CORES-1:0] dWEN,
    input  word_t [NUM_CORES-1:0] iaddr,
    input  word_t [NUM_CORES-1:0] daddr,
    input  word_t [NUM_CORES-1:0] dstore,
    // core-side responses
    output logic [NUM_CORES-1:0] iwait,
    output logic [NUM_CORES-1:0] dwait,
    output word_t [NUM_CORES-1:0] iload,
    output word_t [NUM_CORES-1:0] dload,
    // RAM side
    output logic                 ramREN,
    output logic                 ramWEN,
    output word_t                ramaddr,
    output word_t                ramstore,
    input  word_t                ramload,
    input  ramstate_t            ramstate
);

    arb_state_t state_q, state_d;
    grant_t     grant_q, grant_d;
    core_id_t   last_q,  last_d;

    core_id_t   sel_core;
    req_kind_t  sel_kind;
    logic       sel_valid;

    logic       req_live;
    logic       serving;
    logic       completing;

    arb_select u_arb_select (
        .iren_i      (iREN),
        .dren_i      (dREN),
        .dwen_i      (dWEN),
        .last_core_i (last_q),
        .core_o      (sel_core),
        .kind_o      (sel_kind),
        .valid_o     (sel_valid)
    );

    // Track whether the latched requester is still asking for the RAM.
    always_comb begin
        req_live = 1'b0;
        case (grant_q.kind)
            KIND_IFETCH: req_live = iREN[grant_q.core];
            KIND_DREAD:  req_live = dREN[grant_q.core];
            KIND_DWRITE: req_live = dWEN[grant_q.core];
            default:     req_live = 1'b0;
        endcase
    end

    assign serving    = (state_q == SERVE) && req_live;
    assign completing = serving && (ramstate == ACCESS);

    // Next-state logic: grant in IDLE, retire on ACCESS or on a withdrawn request.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    grant_d.core = sel_core;
                    grant_d.kind = sel_kind;
                    state_d      = SERVE;
                end
            end
            SERVE: begin
                if (!req_live) begin
                    // Abandoned request: leave the arbitration history alone.
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    state_d = IDLE;
                    last_d  = grant_q.core;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, latched grant and last-served core.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= 1'b1;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // RAM drive, wait bits and load routing.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        // A raised request stalls unless it is the one completing this cycle.
        iwait    = iREN;
        dwait    = dREN | dWEN;

        if (serving) begin
            ramREN  = (grant_q.kind != KIND_DWRITE);
            ramWEN  = (grant_q.kind == KIND_DWRITE);
            ramaddr = (grant_q.kind == KIND_IFETCH) ? iaddr[grant_q.core]
                                                    : daddr[grant_q.core];
            if (grant_q.kind == KIND_DWRITE) begin
                ramstore = dstore[grant_q.core];
            end
        end

        if (completing) begin
            if (grant_q.kind == KIND_IFETCH) begin
                iwait[grant_q.core] = 1'b0;
                iload[grant_q.core] = ramload;
            end else begin
                dwait[grant_q.core] = 1'b0;
                dload[grant_q.core] = ramload;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a randomized
// run, all compared against a transaction-level reference model.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       CLK;
    logic       nRST;
    logic [1:0] iREN, dREN, dWEN;
    word_t [1:0] iaddr, daddr, dstore;
    logic [1:0] iwait, dwait;
    word_t [1:0] iload, dload;
    logic       ramREN, ramWEN;
    word_t      ramaddr, ramstore, ramload;
    ramstate_t  ramstate;

    int n_checks = 0;
    int n_errors = 0;
    int done_q[$];      // observed completions: core*4 + kind (0 fetch, 1 read, 2 write)
    int exp_comps = 0;  // completions the model predicted

    ram_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    typedef struct {
        bit busy;   // a transaction is owned
        int core;
        int kind;   // 0 fetch, 1 read, 2 write
        int last;   // core served most recently
    } mstate_t;

    mstate_t m;

    function automatic bit req_bit(int core, int kind);
        case (kind)
            0:       return iREN[core];
            1:       return dREN[core];
            default: return dWEN[core];
        endcase
    endfunction

    function automatic mstate_t model_next(mstate_t s);
        mstate_t n;
        bit r0, r1;
        n  = s;
        r0 = iREN[0] | dREN[0] | dWEN[0];
        r1 = iREN[1] | dREN[1] | dWEN[1];
        if (!s.busy) begin
            if (r0 || r1) begin
                if (r0 && r1) n.core = RR ? 1 - s.last : 0;
                else          n.core = r1 ? 1 : 0;
                n.kind = dWEN[n.core] ? 2 : (dREN[n.core] ? 1 : 0);
                n.busy = 1'b1;
            end
        end else if (!req_bit(s.core, s.kind)) begin
            n.busy = 1'b0;
        end else if (ramstate == ACCESS) begin
            n.busy = 1'b0;
            n.last = s.core;
        end
        return n;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) m <= '{busy: 1'b0, core: 0, kind: 0, last: 1};
        else       m <= model_next(m);
    end

    // Compare every DUT output against the model once per cycle, away from the edge.
    always @(negedge CLK) begin : model_check
        logic [1:0] e_iw, e_dw;
        word_t [1:0] e_il, e_dl;
        logic e_ren, e_wen;
        word_t e_addr, e_st;
        bit live;
        live   = m.busy && req_bit(m.core, m.kind);
        e_iw   = iREN;
        e_dw   = dREN | dWEN;
        e_il   = '0;
        e_dl   = '0;
        e_ren  = live && (m.kind != 2);
        e_wen  = live && (m.kind == 2);
        e_addr = !live ? '0 : ((m.kind == 0) ? iaddr[m.core] : daddr[m.core]);
        e_st   = (live && m.kind == 2) ? dstore[m.core] : '0;
        if (live && ramstate == ACCESS) begin
            exp_comps++;
            if (m.kind == 0) begin
                e_iw[m.core] = 1'b0;
                e_il[m.core] = ramload;
            end else begin
                e_dw[m.core] = 1'b0;
                e_dl[m.core] = ramload;
            end
        end
        n_checks++;
        if ({iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore} !==
            {e_iw, e_dw, e_il, e_dl, e_ren, e_wen, e_addr, e_st}) begin
            n_errors++;
            $display("FAIL model_cycle t=%0t got iw=%b dw=%b il=%h dl=%h ren=%b wen=%b addr=%h st=%h expected iw=%b dw=%b il=%h dl=%h ren=%b wen=%b addr=%h st=%h",
                     $time, iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
                     e_iw, e_dw, e_il, e_dl, e_ren, e_wen, e_addr, e_st);
        end
        // Log what the DUT actually completed, for ordering checks.
        for (int n = 0; n < 2; n++) begin
            if (iREN[n] && !iwait[n]) done_q.push_back(n * 4);
            if ((dREN[n] | dWEN[n]) && !dwait[n]) done_q.push_back(n * 4 + (ramWEN ? 2 : 1));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = FREE;
    endtask

    task automatic quiesce();
        clear_inputs();
        tick(); tick(); tick();
    endtask

    task automatic do_reset();
        clear_inputs();
        nRST = 1'b0;
        tick(); tick();
        nRST = 1'b1;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        nRST = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({ramREN, ramWEN} !== 2'b00) begin
            n_errors++; $display("FAIL reset_ram_en: got %b expected 00", {ramREN, ramWEN});
        end
        n_checks++;
        if ({ramaddr, ramstore} !== 64'h0) begin
            n_errors++; $display("FAIL reset_ram_bus: got %h expected 0", {ramaddr, ramstore});
        end
        n_checks++;
        if ({iload, dload} !== 128'h0) begin
            n_errors++; $display("FAIL reset_loads: got %h expected 0", {iload, dload});
        end
        iREN = 2'b11; dWEN = 2'b01; ramstate = ACCESS; dstore[0] = 32'h5555AAAA;
        @(negedge CLK);
        n_checks++;
        if ({iwait, dwait} !== 4'b1101) begin
            n_errors++; $display("FAIL reset_waits: got %b expected 1101", {iwait, dwait});
        end
        n_checks++;
        if ({ramREN, ramWEN, ramstore} !== 34'h0) begin
            n_errors++; $display("FAIL reset_no_grant: got %h expected 0", {ramREN, ramWEN, ramstore});
        end
        @(posedge CLK); #1;
        clear_inputs();
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        int lat;
        bit seen_low;
        lat = 0; seen_low = 1'b0;
        clear_inputs();
        dREN[0] = 1'b1;
        daddr[0] = 32'h40;
        for (int c = 1; c <= 8 && !seen_low; c++) begin
            ramstate = (c == 3) ? ACCESS : BUSY;
            ramload  = (c == 3) ? 32'hDEADBEEF : 32'h0BAD0BAD;
            @(negedge CLK);
            if (c == 2) begin
                n_checks++;
                if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h40}) begin
                    n_errors++; $display("FAIL read_ram_drive: got %h expected %h", {ramREN, ramWEN, ramaddr}, {2'b10, 32'h40});
                end
            end
            if (dwait[0] === 1'b0) begin
                seen_low = 1'b1;
                lat = c;
                n_checks++;
                if (dload[0] !== 32'hDEADBEEF) begin
                    n_errors++; $display("FAIL read_data: got %h expected deadbeef", dload[0]);
                end
            end
            tick();
        end
        n_checks++;
        if (lat != 3) begin
            n_errors++; $display("FAIL read_latency: got %0d expected 3", lat);
        end
        ramstate = BUSY;
        @(negedge CLK);
        n_checks++;
        if ({dwait[0], dload[0]} !== {1'b1, 32'h0}) begin
            n_errors++; $display("FAIL read_single_pulse: got %h expected %h", {dwait[0], dload[0]}, {1'b1, 32'h0});
        end
        quiesce();
    endtask

    task automatic test_write_priority();
        clear_inputs();
        iREN[0] = 1'b1; dWEN[0] = 1'b1;
        iaddr[0] = 32'h100; daddr[0] = 32'h200; dstore[0] = 32'h12345678;
        ramstate = ACCESS; ramload = 32'hCAFEF00D;
        @(negedge CLK);
        n_checks++;
        if ({ramREN, ramWEN} !== 2'b00) begin
            n_errors++; $display("FAIL wr_idle_no_drive: got %b expected 00", {ramREN, ramWEN});
        end
        tick();
        @(negedge CLK);
        n_checks++;
        if ({ramREN, ramWEN, ramaddr, ramstore} !== {2'b01, 32'h200, 32'h12345678}) begin
            n_errors++; $display("FAIL wr_first: got %h expected %h", {ramREN, ramWEN, ramaddr, ramstore}, {2'b01, 32'h200, 32'h12345678});
        end
        n_checks++;
        if ({iwait[0], dwait[0]} !== 2'b10) begin
            n_errors++; $display("FAIL wr_waits: got %b expected 10", {iwait[0], dwait[0]});
        end
        tick();
        dWEN[0] = 1'b0;
        tick();
        @(negedge CLK);
        n_checks++;
        if ({ramREN, ramWEN, ramaddr, ramstore, iwait[0], iload[0]} !== {2'b10, 32'h100, 32'h0, 1'b0, 32'hCAFEF00D}) begin
            n_errors++; $display("FAIL wr_then_fetch: got %h expected %h", {ramREN, ramWEN, ramaddr, ramstore, iwait[0], iload[0]},
                                 {2'b10, 32'h100, 32'h0, 1'b0, 32'hCAFEF00D});
        end
        quiesce();
    endtask

    task automatic test_tie_policy();
        int got;
        do_reset();
        done_q.delete();
        dREN = 2'b11;
        daddr[0] = 32'h1000; daddr[1] = 32'h2000;
        for (int c = 0; c < 8; c++) begin
            ramstate = (c % 2 == 1) ? ACCESS : BUSY;
            ramload  = $urandom;
            @(negedge CLK);
            tick();
        end
        clear_inputs();
        tick();
        n_checks++;
        if (done_q.size() != 4) begin
            n_errors++; $display("FAIL tie_count: got %0d expected 4", done_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < done_q.size()) ? done_q[i] : -1;
            n_checks++;
            if (got != (RR ? (i % 2) : 0) * 4 + 1) begin
                n_errors++; $display("FAIL tie_grant_%0d: got %0d expected %0d", i, got, (RR ? (i % 2) : 0) * 4 + 1);
            end
        end
        quiesce();
    endtask

    task automatic test_abandon();
        int got;
        do_reset();
        clear_inputs();
        dREN[0] = 1'b1; ramstate = ACCESS;
        tick(); tick();
        dREN[0] = 1'b0;
        iREN[1] = 1'b1; iaddr[1] = 32'h300;
        ramstate = BUSY; ramload = 32'hA5A5A5A5;
        tick();
        @(negedge CLK);
        n_checks++;
        if ({ramREN, ramaddr, iwait[1]} !== {1'b1, 32'h300, 1'b1}) begin
            n_errors++; $display("FAIL abandon_serve: got %h expected %h", {ramREN, ramaddr, iwait[1]}, {1'b1, 32'h300, 1'b1});
        end
        tick();
        iREN[1] = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({iwait[1], iload[1], ramREN} !== 34'h0) begin
            n_errors++; $display("FAIL abandon_drop: got %h expected 0", {iwait[1], iload[1], ramREN});
        end
        tick();
        done_q.delete();
        dREN = 2'b11; ramstate = ACCESS;
        tick();
        tick();
        clear_inputs();
        got = (done_q.size() > 0) ? done_q[0] : -1;
        n_checks++;
        if (got != (RR ? 1 : 0) * 4 + 1) begin
            n_errors++; $display("FAIL abandon_next_tie: got %0d expected %0d", got, (RR ? 1 : 0) * 4 + 1);
        end
        quiesce();
    endtask

    task automatic test_async_reset();
        int got;
        clear_inputs();
        dREN[0] = 1'b1; daddr[0] = 32'h80; ramstate = BUSY;
        tick();
        @(negedge CLK);
        n_checks++;
        if (ramREN !== 1'b1) begin
            n_errors++; $display("FAIL rst_pre_serve: got %b expected 1", ramREN);
        end
        #2 nRST = 1'b0;
        #1;
        n_checks++;
        if ({ramREN, ramWEN, ramaddr, dwait[0], dload[0]} !== {2'b00, 32'h0, 1'b1, 32'h0}) begin
            n_errors++; $display("FAIL rst_async: got %h expected %h", {ramREN, ramWEN, ramaddr, dwait[0], dload[0]}, {2'b00, 32'h0, 1'b1, 32'h0});
        end
        dREN = 2'b11; ramstate = ACCESS;
        @(negedge CLK);
        n_checks++;
        if ({dwait, ramREN} !== 3'b110) begin
            n_errors++; $display("FAIL rst_hold: got %b expected 110", {dwait, ramREN});
        end
        @(posedge CLK); #1;
        done_q.delete();
        nRST = 1'b1;
        tick();
        tick();
        clear_inputs();
        got = (done_q.size() > 0) ? done_q[0] : -1;
        n_checks++;
        if (got != 1) begin
            n_errors++; $display("FAIL rst_first_tie: got %0d expected 1", got);
        end
        quiesce();
    endtask

    task automatic test_error_retry();
        word_t val;
        val = $urandom;
        clear_inputs();
        iREN[1] = 1'b1; iaddr[1] = 32'h500;
        for (int c = 1; c <= 5; c++) begin
            ramstate = (c == 5) ? ACCESS : ERROR;
            ramload  = (c == 5) ? val : ~val;
            @(negedge CLK);
            if (c < 5) begin
                n_checks++;
                if ({iwait[1], iload[1]} !== {1'b1, 32'h0}) begin
                    n_errors++; $display("FAIL err_hold_%0d: got %h expected %h", c, {iwait[1], iload[1]}, {1'b1, 32'h0});
                end
            end else begin
                n_checks++;
                if ({iwait[1], iload[1], ramREN, ramaddr} !== {1'b0, val, 1'b1, 32'h500}) begin
                    n_errors++; $display("FAIL err_complete: got %h expected %h", {iwait[1], iload[1], ramREN, ramaddr}, {1'b0, val, 1'b1, 32'h500});
                end
            end
            tick();
        end
        quiesce();
    endtask

    task automatic test_random();
        do_reset();
        done_q.delete();
        exp_comps = 0;
        for (int c = 0; c < 600; c++) begin
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(0, 3) == 0) iREN[n] = ~iREN[n];
                if ($urandom_range(0, 3) == 0) dREN[n] = ~dREN[n];
                if ($urandom_range(0, 5) == 0) dWEN[n] = ~dWEN[n];
                iaddr[n]  = $urandom;
                daddr[n]  = $urandom;
                dstore[n] = $urandom;
            end
            ramstate = ramstate_t'($urandom_range(0, 3));
            ramload  = $urandom;
            tick();
        end
        quiesce();
        n_checks++;
        if (done_q.size() != exp_comps || exp_comps == 0) begin
            n_errors++; $display("FAIL random_completions: got %0d expected %0d (nonzero)", done_q.size(), exp_comps);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        CLK = 1'b0;
        nRST = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_write_priority();
        test_tie_policy();
        test_abandon();
        test_async_reset();
        test_error_retry();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
